// File: rtl/b8_core_pkg.sv
// b8_core_pkg: shared core definitions.
//   XLEN        - integer datapath width
//   REG_ADDR_W  - register index width (32 architectural registers)
//   REG_NUM     - number of architectural registers
//   wb_state_t  - writeback commit FSM state: W0 awaits way0 of the current
//                 pair, W1 awaits way1 of the current pair.
package b8_core_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    typedef enum logic {
        W0 = 1'b0,
        W1 = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding packed writeback entries
// ({addr, we, data, pid} as assembled by the caller).
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   flush         - synchronous clear; wins over push and pop in the same cycle
//   push/pushData - write an entry (ignored when full or flushing)
//   pop           - drop the head entry (ignored when empty or flushing)
//   head          - current oldest entry (meaningful only when !empty)
//   empty, full   - occupancy flags
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit so
// that equal indices can be told apart as empty (same wrap) or full
// (different wrap).
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 71
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wrPtr;
    logic [AW:0]  rdPtr;
    logic         doPush;
    logic         doPop;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign head  = mem[rdPtr[AW-1:0]];

    // Push is refused when full even if a pop happens the same cycle, so the
    // caller's ready (= !full) stays independent of the pop decision.
    assign doPush = push && !full && !flush;
    assign doPop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while the pointers say
    // they are occupied.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/wb_commit.sv
// wb_commit: dual-way writeback/commit stage.
// Results from the two execution ways are buffered in per-way FIFOs and
// retired in program order (way0 then way1 of each pair; pairs matched by a
// 1-bit pair ID). Two registered write ports feed the 32x64 register file.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   flush_i                 - synchronous flush of all buffered results
//   wayN_valid_i/ready_o    - per-way result handshake
//   wayN_rdAddr_i/rdWriteEnable_i/rdData_i/pID_i - per-way result payload
//   wbN_writeEnable_o/rdAddr_o/rdData_o          - registered regfile writes
//   retire_cnt_o            - entries retired in the previous cycle (0..2)
//   pid_err_o               - sticky head pair-ID mismatch flag
//   dbgState_o              - current commit FSM state
//   retired_total_o         - running retire count (only with WB_PERF_CNT_EN)
// Handshake: a result is taken on a clock edge where wayN_valid_i && wayN_ready_o;
// ready depends only on FIFO fullness, never on valid, and a held-off
// producer keeps its payload stable until it is taken.
module wb_commit
    import b8_core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = b8_core_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush_i,
    input  logic                  way0_valid_i,
    output logic                  way0_ready_o,
    input  logic [REG_ADDR_W-1:0] way0_rdAddr_i,
    input  logic                  way0_rdWriteEnable_i,
    input  logic [XLEN-1:0]       way0_rdData_i,
    input  logic                  way0_pID_i,
    input  logic                  way1_valid_i,
    output logic                  way1_ready_o,
    input  logic [REG_ADDR_W-1:0] way1_rdAddr_i,
    input  logic                  way1_rdWriteEnable_i,
    input  logic [XLEN-1:0]       way1_rdData_i,
    input  logic                  way1_pID_i,
    output logic                  wb0_writeEnable_o,
    output logic [REG_ADDR_W-1:0] wb0_rdAddr_o,
    output logic [XLEN-1:0]       wb0_rdData_o,
    output logic                  wb1_writeEnable_o,
    output logic [REG_ADDR_W-1:0] wb1_rdAddr_o,
    output logic [XLEN-1:0]       wb1_rdData_o,
    output logic [1:0]            retire_cnt_o,
    output logic                  pid_err_o,
    output wb_state_t             dbgState_o
`ifdef WB_PERF_CNT_EN
    ,
    output logic [63:0]           retired_total_o
`endif
);

    // Entry layout: {addr, we, data, pid}
    localparam int EW = REG_ADDR_W + 1 + XLEN + 1;

    logic [EW-1:0] head0, head1;
    logic          empty0, empty1, full0, full1;

    logic [REG_ADDR_W-1:0] h0Addr, h1Addr;
    logic                  h0We, h1We, h0Pid, h1Pid;
    logic [XLEN-1:0]       h0Data, h1Data;
    logic                  h0Valid, h1Valid;

    wb_state_t state, nextState;
    logic      expPid, nextPid;
    logic      retire0, retire1, pidMismatch;
    logic      write0, write1, write0Final;

    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush_i),
        .push     (way0_valid_i),
        .pushData ({way0_rdAddr_i, way0_rdWriteEnable_i, way0_rdData_i, way0_pID_i}),
        .pop      (retire0),
        .head     (head0),
        .empty    (empty0),
        .full     (full0)
    );

    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush_i),
        .push     (way1_valid_i),
        .pushData ({way1_rdAddr_i, way1_rdWriteEnable_i, way1_rdData_i, way1_pID_i}),
        .pop      (retire1),
        .head     (head1),
        .empty    (empty1),
        .full     (full1)
    );

    assign way0_ready_o = !full0;
    assign way1_ready_o = !full1;

    assign {h0Addr, h0We, h0Data, h0Pid} = head0;
    assign {h1Addr, h1We, h1Data, h1Pid} = head1;
    assign h0Valid = !empty0;
    assign h1Valid = !empty1;

    // Retire decision. In W0 a way1 head must belong to the current pair,
    // so its ID is checked too; in W1 a way0 head may already belong to the
    // next pair and is therefore not checked.
    always_comb begin
        retire0     = 1'b0;
        retire1     = 1'b0;
        pidMismatch = 1'b0;
        nextState   = state;
        nextPid     = expPid;
        case (state)
            W0: begin
                if (h0Valid && h0Pid == expPid) begin
                    retire0 = 1'b1;
                    if (h1Valid && h1Pid == expPid) begin
                        retire1 = 1'b1;
                        nextPid = ~expPid;
                    end else begin
                        nextState = W1;
                    end
                end else if (h0Valid) begin
                    pidMismatch = 1'b1;
                end
                if (h1Valid && h1Pid != expPid) pidMismatch = 1'b1;
            end
            W1: begin
                if (h1Valid && h1Pid == expPid) begin
                    retire1   = 1'b1;
                    nextPid   = ~expPid;
                    nextState = W0;
                end else if (h1Valid) begin
                    pidMismatch = 1'b1;
                end
            end
            default: nextState = W0;
        endcase
    end

    // x0 writes are dropped; when both ways of a pair hit the same rd the
    // younger (way1) write is the only one kept.
    assign write0      = retire0 && h0We && (h0Addr != '0);
    assign write1      = retire1 && h1We && (h1Addr != '0);
    assign write0Final = write0 && !(write1 && (h1Addr == h0Addr));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= W0;
            expPid            <= 1'b0;
            pid_err_o         <= 1'b0;
            wb0_writeEnable_o <= 1'b0;
            wb0_rdAddr_o      <= '0;
            wb0_rdData_o      <= '0;
            wb1_writeEnable_o <= 1'b0;
            wb1_rdAddr_o      <= '0;
            wb1_rdData_o      <= '0;
            retire_cnt_o      <= 2'd0;
        end else if (flush_i) begin
            state             <= W0;
            expPid            <= 1'b0;
            pid_err_o         <= 1'b0;
            wb0_writeEnable_o <= 1'b0;
            wb0_rdAddr_o      <= '0;
            wb0_rdData_o      <= '0;
            wb1_writeEnable_o <= 1'b0;
            wb1_rdAddr_o      <= '0;
            wb1_rdData_o      <= '0;
            retire_cnt_o      <= 2'd0;
        end else begin
            state             <= nextState;
            expPid            <= nextPid;
            pid_err_o         <= pid_err_o | pidMismatch;
            wb0_writeEnable_o <= write0Final;
            wb0_rdAddr_o      <= retire0 ? h0Addr : '0;
            wb0_rdData_o      <= retire0 ? h0Data : '0;
            wb1_writeEnable_o <= write1;
            wb1_rdAddr_o      <= retire1 ? h1Addr : '0;
            wb1_rdData_o      <= retire1 ? h1Data : '0;
            retire_cnt_o      <= {retire0 & retire1, retire0 ^ retire1};
        end
    end

    assign dbgState_o = state;

`ifdef WB_PERF_CNT_EN
    // Lifetime retire counter; survives flushes, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) retired_total_o <= 64'd0;
        else          retired_total_o <= retired_total_o + {62'd0, retire_cnt_o};
    end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: directed self-checking bench for wb_commit.
module tb_wb_commit;
    import b8_core_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        flush_i;
    logic        way0_valid_i, way1_valid_i;
    logic        way0_ready_o, way1_ready_o;
    logic [4:0]  way0_rdAddr_i, way1_rdAddr_i;
    logic        way0_rdWriteEnable_i, way1_rdWriteEnable_i;
    logic [63:0] way0_rdData_i, way1_rdData_i;
    logic        way0_pID_i, way1_pID_i;
    logic        wb0_writeEnable_o, wb1_writeEnable_o;
    logic [4:0]  wb0_rdAddr_o, wb1_rdAddr_o;
    logic [63:0] wb0_rdData_o, wb1_rdData_o;
    logic [1:0]  retire_cnt_o;
    logic        pid_err_o;
    wb_state_t   dbgState_o;
`ifdef WB_PERF_CNT_EN
    logic [63:0] retired_total_o;
`endif

    int total = 0;
    int bad   = 0;

    wb_commit #(.DEPTH(4), .XLEN(64)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .flush_i              (flush_i),
        .way0_valid_i         (way0_valid_i),
        .way0_ready_o         (way0_ready_o),
        .way0_rdAddr_i        (way0_rdAddr_i),
        .way0_rdWriteEnable_i (way0_rdWriteEnable_i),
        .way0_rdData_i        (way0_rdData_i),
        .way0_pID_i           (way0_pID_i),
        .way1_valid_i         (way1_valid_i),
        .way1_ready_o         (way1_ready_o),
        .way1_rdAddr_i        (way1_rdAddr_i),
        .way1_rdWriteEnable_i (way1_rdWriteEnable_i),
        .way1_rdData_i        (way1_rdData_i),
        .way1_pID_i           (way1_pID_i),
        .wb0_writeEnable_o    (wb0_writeEnable_o),
        .wb0_rdAddr_o         (wb0_rdAddr_o),
        .wb0_rdData_o         (wb0_rdData_o),
        .wb1_writeEnable_o    (wb1_writeEnable_o),
        .wb1_rdAddr_o         (wb1_rdAddr_o),
        .wb1_rdData_o         (wb1_rdData_o),
        .retire_cnt_o         (retire_cnt_o),
        .pid_err_o            (pid_err_o),
        .dbgState_o           (dbgState_o)
`ifdef WB_PERF_CNT_EN
        ,
        .retired_total_o      (retired_total_o)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive0(input logic [4:0] a, input logic we, input logic [63:0] d, input logic p);
        way0_valid_i = 1'b1; way0_rdAddr_i = a; way0_rdWriteEnable_i = we;
        way0_rdData_i = d; way0_pID_i = p;
    endtask

    task automatic drive1(input logic [4:0] a, input logic we, input logic [63:0] d, input logic p);
        way1_valid_i = 1'b1; way1_rdAddr_i = a; way1_rdWriteEnable_i = we;
        way1_rdData_i = d; way1_pID_i = p;
    endtask

    task automatic idle();
        way0_valid_i = 1'b0;
        way1_valid_i = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_we0"}, 64'(wb0_writeEnable_o), 64'd0);
        chk({tag, "_we1"}, 64'(wb1_writeEnable_o), 64'd0);
        chk({tag, "_cnt"}, 64'(retire_cnt_o), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; flush_i = 1'b0;
        way0_valid_i = 0; way0_rdAddr_i = 0; way0_rdWriteEnable_i = 0; way0_rdData_i = 0; way0_pID_i = 0;
        way1_valid_i = 0; way1_rdAddr_i = 0; way1_rdWriteEnable_i = 0; way1_rdData_i = 0; way1_pID_i = 0;
        step(); step();
        chk_quiet("rst");
        chk("rst_err", 64'(pid_err_o), 64'd0);
        chk("rst_rdy0", 64'(way0_ready_o), 64'd1);
        chk("rst_rdy1", 64'(way1_ready_o), 64'd1);
        chk("rst_state", 64'(dbgState_o), 64'(W0));
        reset_n = 1'b1;
        step();

        // 1. same-cycle pair, pid0
        drive0(5'd5, 1'b1, 64'h11, 1'b0);
        drive1(5'd6, 1'b1, 64'h22, 1'b0);
        step(); idle();
        chk_quiet("t1_lat");
        step();
        chk("t1_we0", 64'(wb0_writeEnable_o), 64'd1);
        chk("t1_a0", 64'(wb0_rdAddr_o), 64'd5);
        chk("t1_d0", wb0_rdData_o, 64'h11);
        chk("t1_we1", 64'(wb1_writeEnable_o), 64'd1);
        chk("t1_a1", 64'(wb1_rdAddr_o), 64'd6);
        chk("t1_d1", wb1_rdData_o, 64'h22);
        chk("t1_cnt", 64'(retire_cnt_o), 64'd2);
        step();
        chk_quiet("t1_after");

        // flush to restart pair numbering at 0
        flush_i = 1'b1; step(); flush_i = 1'b0;
        chk("f1_state", 64'(dbgState_o), 64'(W0));

        // 2. split pair: way0 now, way1 three cycles later
        drive0(5'd7, 1'b1, 64'hA, 1'b0);
        step(); idle();                 // push edge A
        step();                         // edge A+1
        chk("t2_we0", 64'(wb0_writeEnable_o), 64'd1);
        chk("t2_a0", 64'(wb0_rdAddr_o), 64'd7);
        chk("t2_d0", wb0_rdData_o, 64'hA);
        chk("t2_we1", 64'(wb1_writeEnable_o), 64'd0);
        chk("t2_cnt1", 64'(retire_cnt_o), 64'd1);
        chk("t2_state", 64'(dbgState_o), 64'(W1));
        step();                         // edge A+2
        chk_quiet("t2_gap");
        drive1(5'd8, 1'b1, 64'hB, 1'b0);
        step(); idle();                 // edge A+3 push
        chk_quiet("t2_gap2");
        step();
        chk("t2_we1b", 64'(wb1_writeEnable_o), 64'd1);
        chk("t2_a1", 64'(wb1_rdAddr_o), 64'd8);
        chk("t2_d1", wb1_rdData_o, 64'hB);
        chk("t2_we0b", 64'(wb0_writeEnable_o), 64'd0);
        chk("t2_cnt2", 64'(retire_cnt_o), 64'd1);

        // 3. pair pid1, both target x9: younger wins
        drive0(5'd9, 1'b1, 64'h1, 1'b1);
        drive1(5'd9, 1'b1, 64'h2, 1'b1);
        step(); idle(); step();
        chk("t3_we0", 64'(wb0_writeEnable_o), 64'd0);
        chk("t3_we1", 64'(wb1_writeEnable_o), 64'd1);
        chk("t3_a1", 64'(wb1_rdAddr_o), 64'd9);
        chk("t3_d1", wb1_rdData_o, 64'h2);
        chk("t3_cnt", 64'(retire_cnt_o), 64'd2);

        // 4. way0 writes x0 (suppressed), then a no-write way1 instruction
        drive0(5'd0, 1'b1, 64'h55, 1'b0);
        step(); idle(); step();
        chk("t4_we0", 64'(wb0_writeEnable_o), 64'd0);
        chk("t4_cnt", 64'(retire_cnt_o), 64'd1);
        drive1(5'd10, 1'b0, 64'h66, 1'b0);
        step(); idle(); step();
        chk("t4_we1", 64'(wb1_writeEnable_o), 64'd0);
        chk("t4_cnt2", 64'(retire_cnt_o), 64'd1);
        chk("t4_state", 64'(dbgState_o), 64'(W0));

        // 5. pair-ID mismatch at the head, sticky until flush
        flush_i = 1'b1; step(); flush_i = 1'b0;
        chk("t5_err0", 64'(pid_err_o), 64'd0);
        drive0(5'd11, 1'b1, 64'h77, 1'b1);
        step(); idle(); step();
        chk("t5_err1", 64'(pid_err_o), 64'd1);
        chk_quiet("t5_noret");
        step();
        chk("t5_sticky", 64'(pid_err_o), 64'd1);
        chk("t5_cnt", 64'(retire_cnt_o), 64'd0);
        // flush with a simultaneous push: the push is dropped
        flush_i = 1'b1;
        drive0(5'd13, 1'b1, 64'h13, 1'b0);
        step(); flush_i = 1'b0; idle();
        chk("t5_errclr", 64'(pid_err_o), 64'd0);
        step();
        chk_quiet("t5_empty");
        drive0(5'd12, 1'b1, 64'h12, 1'b0);
        step(); idle(); step();
        chk("t5_we0", 64'(wb0_writeEnable_o), 64'd1);
        chk("t5_a0", 64'(wb0_rdAddr_o), 64'd12);
        chk("t5_d0", wb0_rdData_o, 64'h12);

        // 6. fill way0 while the FSM waits for way1 of pair 0
        for (int i = 0; i < 4; i++) begin
            drive0(5'(21 + i), 1'b1, 64'(i), 1'(i % 2 == 0));
            step();
            chk($sformatf("t6_rdy%0d", i), 64'(way0_ready_o), (i == 3) ? 64'd0 : 64'd1);
        end
        drive0(5'd25, 1'b1, 64'h25, 1'b0);
        step();
        chk("t6_held_rdy", 64'(way0_ready_o), 64'd0);
        chk("t6_held_cnt", 64'(retire_cnt_o), 64'd0);
        idle();
        drive1(5'd20, 1'b1, 64'h20, 1'b0);
        step(); idle(); step();
        chk("t6_we1", 64'(wb1_writeEnable_o), 64'd1);
        chk("t6_a1", 64'(wb1_rdAddr_o), 64'd20);
        // reset mid-operation
        reset_n = 1'b0;
        #1;
        chk_quiet("t6_rst");
        chk("t6_rst_a1", 64'(wb1_rdAddr_o), 64'd0);
        chk("t6_rst_rdy0", 64'(way0_ready_o), 64'd1);
        chk("t6_rst_state", 64'(dbgState_o), 64'(W0));
        step();
        reset_n = 1'b1;
        step(); step();
        chk_quiet("t6_post");
        drive0(5'd3, 1'b1, 64'h33, 1'b0);
        drive1(5'd4, 1'b1, 64'h44, 1'b0);
        step(); idle(); step();
        chk("t6_p_a0", 64'(wb0_rdAddr_o), 64'd3);
        chk("t6_p_d0", wb0_rdData_o, 64'h33);
        chk("t6_p_d1", wb1_rdData_o, 64'h44);
        chk("t6_p_cnt", 64'(retire_cnt_o), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
